wall_map: RTL

WALL_MAP -- requirements
Module: wall_map

---
 rtl/bomber_pkg.sv | 49 ++++
 rtl/wall_map_ram.sv | 33 +++
 rtl/wall_map.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bomber_pkg.sv
// Shared definitions for the bomber playfield: tile size, default grid
// dimensions, tile codes, wall-map FSM states and the map-fill helpers.
// Also used by the wall renderer, which consumes the tile codes.
package bomber_pkg;

    localparam int unsigned TILE_SIZE = 32;
    localparam int unsigned MAP_COLS  = 800 / TILE_SIZE;  // 25
    localparam int unsigned MAP_ROWS  = 600 / TILE_SIZE;  // 18 (truncated)

    typedef enum logic [3:0] {
        TILE_EMPTY = 4'd0,
        TILE_SOLID = 4'd1,
        TILE_BRICK = 4'd2
    } tile_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP
    } wall_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Tile written at (cx,cy) during the fill. The fixed pillar grid takes
    // priority over the start-area clearing, so (COLS-3,ROWS-2) stays a pillar
    // when it lands on even/even coordinates.
    function automatic tile_e init_tile(input int unsigned cx, input int unsigned cy,
                                        input int unsigned cols, input int unsigned rows,
                                        input logic [2:0] rnd);
        tile_e t;
        if (cx == 0 || cx == cols - 1 || cy == 0 || cy == rows - 1 ||
            (cx[0] == 1'b0 && cy[0] == 1'b0))
            t = TILE_SOLID;
        else if ((cx == 1 && cy == 1) || (cx == 2 && cy == 1) || (cx == 1 && cy == 2) ||
                 (cx == cols - 2 && cy == rows - 2) || (cx == cols - 3 && cy == rows - 2) ||
                 (cx == cols - 2 && cy == rows - 3))
            t = TILE_EMPTY;
        else if (rnd < 3'd5)
            t = TILE_BRICK;
        else
            t = TILE_EMPTY;
        return t;
    endfunction

endpackage

// File: rtl/wall_map_ram.sv
// Wall map storage: 1R + 1RW synchronous RAM with registered read data.
// A read and a write to the same cell in one cycle return the old value.
//   clk               - clock
//   rd_addr/rd_data   - read-only port (renderer side)
//   rw_addr/rw_we/rw_wdata/rw_rdata - read/write port (fill and hit logic)
module wall_map_ram #(
    parameter int unsigned DEPTH  = 450,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_data,
    input  logic [ADDR_W-1:0] rw_addr,
    input  logic              rw_we,
    input  logic [3:0]        rw_wdata,
    output logic [3:0]        rw_rdata
);

    logic [3:0] mem [DEPTH];
    logic [3:0] rd_data_q;
    logic [3:0] rw_rdata_q;

    always_ff @(posedge clk) begin
        rd_data_q  <= mem[rd_addr];
        rw_rdata_q <= mem[rw_addr];
        if (rw_we)
            mem[rw_addr] <= rw_wdata;
    end

    assign rd_data  = rd_data_q;
    assign rw_rdata = rw_rdata_q;

endmodule

// File: rtl/wall_map.sv
// Bomber wall map: fills the tile grid after reset (pillars, border,
// LFSR-placed bricks), serves registered renderer reads and handles
// explosion hit requests, clearing bricks that are hit.
//   clk, reset                 - clock, synchronous active-high reset
//   rd_cx, rd_cy -> rd_tile    - renderer read, one cycle latency
//   init_done                  - map fill finished
//   req_valid/req_ready, req_cx/req_cy - hit request handshake
//   resp_valid/resp_brick/resp_block   - one-cycle hit result
module wall_map
    import bomber_pkg::*;
#(
    parameter int unsigned COLS = MAP_COLS,
    parameter int unsigned ROWS = MAP_ROWS,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rd_cx,
    input  logic [4:0] rd_cy,
    output logic [3:0] rd_tile,
    output logic       init_done,
    input  logic       req_valid,
    input  logic [4:0] req_cx,
    input  logic [4:0] req_cy,
    output logic       req_ready,
    output logic       resp_valid,
    output logic       resp_brick,
    output logic       resp_block
);

    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 9;

    wall_state_e       state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [4:0]        init_cx_q, init_cx_d;
    logic [4:0]        init_cy_q, init_cy_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              init_done_q, init_done_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_oob_q, req_oob_d;
    logic              rd_ok_q, rd_ok_d;

    logic              rd_in_range, req_in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_rw_addr;
    logic              ram_we;
    logic [3:0]        ram_wdata;
    logic [3:0]        ram_rd_data;
    logic [3:0]        ram_rw_rdata;

    // Out-of-range coordinates are steered to address 0 so the RAM is never
    // indexed past its depth; the range flag masks the result instead.
    always_comb begin
        rd_in_range  = (32'(rd_cx) < COLS) && (32'(rd_cy) < ROWS);
        req_in_range = (32'(req_cx) < COLS) && (32'(req_cy) < ROWS);
        rd_addr      = rd_in_range ? ADDR_W'(32'(rd_cy) * COLS + 32'(rd_cx)) : '0;
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_cx_d   = init_cx_q;
        init_cy_d   = init_cy_q;
        lfsr_d      = lfsr_q;
        init_done_d = init_done_q;
        req_addr_d  = req_addr_q;
        req_oob_d   = req_oob_q;
        rd_ok_d     = init_done_q && rd_in_range;
        ram_rw_addr = req_addr_q;
        ram_we      = 1'b0;
        ram_wdata   = TILE_EMPTY;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_brick  = 1'b0;
        resp_block  = 1'b0;

        case (state_q)
            ST_INIT: begin
                ram_rw_addr = init_addr_q;
                ram_we      = 1'b1;
                ram_wdata   = init_tile(32'(init_cx_q), 32'(init_cy_q), COLS, ROWS, lfsr_q[2:0]);
                lfsr_d      = lfsr_step(lfsr_q);
                if (32'(init_addr_q) == CELLS - 1) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                    if (32'(init_cx_q) == COLS - 1) begin
                        init_cx_d = '0;
                        init_cy_d = init_cy_q + 1'b1;
                    end else begin
                        init_cx_d = init_cx_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_addr_d = req_in_range ? ADDR_W'(32'(req_cy) * COLS + 32'(req_cx)) : '0;
                    req_oob_d  = !req_in_range;
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (req_oob_q) begin
                    resp_block = 1'b1;
                end else begin
                    resp_brick = (ram_rw_rdata == TILE_BRICK);
                    resp_block = (ram_rw_rdata == TILE_BRICK) || (ram_rw_rdata == TILE_SOLID);
                    ram_we     = (ram_rw_rdata == TILE_BRICK);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_cx_q   <= '0;
            init_cy_q   <= '0;
            lfsr_q      <= SEED;
            init_done_q <= 1'b0;
            req_addr_q  <= '0;
            req_oob_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_cx_q   <= init_cx_d;
            init_cy_q   <= init_cy_d;
            lfsr_q      <= lfsr_d;
            init_done_q <= init_done_d;
            req_addr_q  <= req_addr_d;
            req_oob_q   <= req_oob_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    wall_map_ram #(
        .DEPTH (CELLS),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data),
        .rw_addr (ram_rw_addr),
        .rw_we   (ram_we),
        .rw_wdata(ram_wdata),
        .rw_rdata(ram_rw_rdata)
    );

    // rd_ok_q travels alongside the RAM's registered read data.
    assign rd_tile   = rd_ok_q ? ram_rd_data : TILE_EMPTY;
    assign init_done = init_done_q;

endmodule
